// File: rtl/tile_l1_preloader.sv
// tile_l1_preloader: streams a linear word image into the word-interleaved
// tile L1 banks. Word address A goes to bank A % N_MEM_BANKS, row
// A / N_MEM_BANKS. A one-entry holding register decouples the input stream
// from bank grants.
// Optional feature macro: TILE_PRELOAD_CHECKSUM_EN (running sum of granted
// write data on checksum_o; when undefined checksum_o is tied to 0).
module tile_l1_preloader #(
  parameter int N_MEM_BANKS  = 32,
  parameter int N_WORDS_BANK = 8192,
  parameter int DATA_W       = 32,
  localparam int BANK_AW     = $clog2(N_WORDS_BANK),
  localparam int BW          = $clog2(N_MEM_BANKS),
  localparam int AW          = $clog2(N_MEM_BANKS * N_WORDS_BANK),
  localparam int LW          = AW + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AW-1:0]          base_addr_i,
  input  logic [LW-1:0]          len_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [N_MEM_BANKS-1:0] bank_req_o,
  output logic                   bank_we_o,
  output logic [BANK_AW-1:0]     bank_addr_o,
  output logic [DATA_W-1:0]      bank_wdata_o,
  output logic [DATA_W/8-1:0]    bank_be_o,
  input  logic [N_MEM_BANKS-1:0] bank_gnt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [DATA_W-1:0]      checksum_o
);

  // Total image capacity, widened so base + len can never overflow the compare.
  localparam logic [LW:0] TOTAL_WORDS = (LW+1)'(N_MEM_BANKS * N_WORDS_BANK);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       cur;
  logic [LW-1:0]       rem;
  logic [LW-1:0]       acc_cnt;
  logic                hv;
  logic [DATA_W-1:0]   hdata;
  logic [AW-1:0]       haddr;

  logic [LW:0]         end_addr;
  logic                range_err;
  logic                start_ok;
  logic                gnt_hit;
  logic                accept;

  assign end_addr  = {2'b00, base_addr_i} + {1'b0, len_i};
  assign range_err = end_addr > TOTAL_WORDS;
  assign start_ok  = (state == IDLE) && start_i;

  // Request is a pure function of the holding register, so it is stable
  // for as long as the word waits for its grant.
  assign bank_req_o   = hv ? (N_MEM_BANKS'(1) << haddr[BW-1:0]) : '0;
  assign bank_addr_o  = hv ? haddr[AW-1:BW] : '0;
  assign bank_wdata_o = hv ? hdata : '0;
  assign bank_we_o    = hv;
  assign bank_be_o    = hv ? '1 : '0;

  // Only a grant on the requested bank counts; other grant bits are masked out.
  assign gnt_hit = |(bank_req_o & bank_gnt_i);
  assign accept  = valid_i && ready_o;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0 || range_err) state_nxt = FINISH;
          else                          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (gnt_hit && rem == LW'(1)) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; holding slot frees up on the grant cycle
  always_comb begin
    busy_o  = (state == LOAD);
    done_o  = (state == FINISH);
    ready_o = (state == LOAD) && (!hv || gnt_hit) && (acc_cnt != '0);
  end

  // Control counters, holding-slot valid and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur     <= '0;
      rem     <= '0;
      acc_cnt <= '0;
      hv      <= 1'b0;
      err_o   <= 1'b0;
    end else if (start_ok) begin
      cur     <= base_addr_i;
      rem     <= len_i;
      acc_cnt <= len_i;
      hv      <= 1'b0;
      err_o   <= range_err;
    end else if (state == LOAD) begin
      if (accept) begin
        cur     <= cur + AW'(1);
        acc_cnt <= acc_cnt - LW'(1);
        hv      <= 1'b1;
      end else if (gnt_hit) begin
        hv      <= 1'b0;
      end
      if (gnt_hit) rem <= rem - LW'(1);
    end
  end

  // Holding register payload; qualified by hv so it needs no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      hdata <= data_i;
      haddr <= cur;
    end
  end

`ifdef TILE_PRELOAD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  // Running modulo-2^DATA_W sum of every granted write word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (gnt_hit)  checksum <= checksum + bank_wdata_o;
  end

  assign checksum_o = checksum;
`else
  assign checksum_o = '0;
`endif

endmodule
